div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have the following ports, one per line:
  clk  in  1  rising-edge clock
  rst  in  1  reset; synchronous, active-high
  signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
  opdata1_i  in  32  dividend
  opdata2_i  in  32  divisor
  start_i  in  1  request; held high by the ALU until ready_o is seen
  annul_i  in  1  abort the current division (pipeline flush)
  result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
  ready_o  out  1  result_o valid
REQ-002 There SHALL be no parameters; all widths are fixed at 32-bit operands and a 64-bit result.

Function
REQ-003 The FSM SHALL have four states, FREE, BYZERO, ON and END, with the following transitions:
  - FREE -> BYZERO when start_i=1 and annul_i=0 and opdata2_i=0.
  - FREE -> ON when start_i=1 and annul_i=0 and opdata2_i!=0.
  - BYZERO -> END unconditionally.
  - ON -> FREE when annul_i=1.
  - ON -> END after 32 iterations.
  - END -> FREE when start_i=0.
REQ-004 On FREE->ON the block SHALL capture signed_div_i and both operands; later operand changes SHALL have no effect.
REQ-005 In signed mode, the captured operands SHALL be replaced by their two's-complement absolute values, and the original sign bits SHALL be stored.
REQ-006 ON SHALL perform one restoring-division step per cycle:
  - 33-bit trial subtract of the divisor from {partial remainder, next dividend bit}.
  - The quotient bit is the inverted borrow.
  - A 6-bit counter runs 0..31.
REQ-007 On entry to END from ON, the quotient SHALL be negated if signed and the signs differ; the remainder SHALL be negated if signed and the dividend is negative.
REQ-008 Latency: with start sampled at edge N, ready_o=1 and result_o valid SHALL appear from edge N+33 (ON) or edge N+2 (BYZERO).
REQ-009 ready_o and result_o SHALL be registered and held constant throughout END; in all other states ready_o=0 and result_o=0.
REQ-010 Division by zero SHALL produce result_o=64'h0 with ready_o asserted.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-012 annul_i=1 in ON SHALL return to FREE on the next edge with ready_o=0; annul_i in FREE blocks start.
REQ-013 annul_i SHALL be ignored in BYZERO and END.
REQ-014 start_i=1 arriving while not in FREE SHALL be ignored.
REQ-015 Back-to-back divides SHALL require start_i to drop for at least one cycle (END->FREE) before the next start is accepted.
REQ-016 In ON, the block SHALL treat start_i falling as an implicit abort: return to FREE next edge with ready_o=0.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL force state FREE, counter=0, ready_o=0 and result_o=0, and clear all internal operand and sign registers.
REQ-018 Reset mid-operation (ON, BYZERO or END) SHALL abandon the division with no result produced; the next start after rst falls SHALL begin a fresh division.

Structure
REQ-019 The state encodings (DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END, 2-bit) and the constants DIV_RESULT_READY/NOT_READY and DIV_START/STOP SHALL reside in the shared defines header alongside the EXE_*_OP codes.
REQ-020 One combinational sub-module, div_step, SHALL implement a single trial-subtract iteration (inputs: 64-bit working register and 32-bit divisor; outputs: next working register and quotient bit); div_seq instantiates it once.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - Unsigned 100 / 7 -> ready_o at N+33, result_o = {32'd2, 32'd14}; ready_o holds until start_i drops, then 0 the next cycle.
  - Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - Signed 0x80000000 / 0xFFFFFFFF -> result_o = {32'h0, 32'h80000000}; unsigned 0xFFFFFFFF / 1 -> {32'h0, 32'hFFFFFFFF}.
  - Divisor 0 -> ready_o at N+2 with result_o = 64'h0; change opdata1_i/opdata2_i mid-ON -> result unchanged.
  - annul_i pulse at cycle N+10 -> ready_o never asserts, FSM in FREE at N+11, and a new 20 / 3 completes with {32'd2, 32'd6}.
  - rst pulse at cycle N+15 -> ready_o=0 and result_o=0 from the next edge; no stale result appears afterwards.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, handshake constants,
// ALU opcodes that select it, and a conditional two's-complement helper.
package div_seq_pkg;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [7:0] {
        EXE_NOP_OP  = 8'b0000_0000,
        EXE_MULT_OP = 8'b0001_1000,
        EXE_MULTU_OP = 8'b0001_1001,
        EXE_DIV_OP  = 8'b0001_1010,
        EXE_DIVU_OP = 8'b0001_1011
    } exe_op_e;

    function automatic logic [31:0] neg_if(input logic [31:0] value, input logic enable);
        return enable ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration on the {remainder, dividend} working register.
module div_step
    import div_seq_pkg::*;
(
    input  logic [63:0] work,
    input  logic [31:0] divisor,
    output logic [63:0] work_next,
    output logic        q_bit
);

    logic [32:0] trial;
    logic [31:0] diff;

    always_comb begin
        trial = work[63:31];
        // Remainder stays below the divisor, so a successful subtract fits in 32 bits.
        diff  = trial[31:0] - divisor;
        q_bit = (trial >= {1'b0, divisor});
        if (q_bit) begin
            work_next = {diff, work[30:0], 1'b1};
        end else begin
            work_next = {work[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit signed/unsigned divider: 32 restoring steps on absolute values,
// sign fix-up on the last step, result held while the requester keeps start_i high.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    logic [1:0]  state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [63:0] work_reg, work_next;
    logic [31:0] divisor_reg, divisor_next;
    logic        signed_reg, signed_next;
    logic        sign1_reg, sign1_next;
    logic        sign2_reg, sign2_next;
    logic [63:0] result_reg, result_next;
    logic        ready_reg, ready_next;

    logic [63:0] step_work;
    logic        step_q;
    logic [31:0] final_quot;
    logic [31:0] final_rem;

    div_step u_step (
        .work      (work_reg),
        .divisor   (divisor_reg),
        .work_next (step_work),
        .q_bit     (step_q)
    );

    assign final_quot = {step_work[31:1], step_q};
    assign final_rem  = step_work[63:32];

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        signed_next  = signed_reg;
        sign1_next   = sign1_reg;
        sign2_next   = sign2_reg;
        result_next  = 64'h0;
        ready_next   = DIV_RESULT_NOT_READY;

        case (state_reg)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        state_next = DIV_BYZERO;
                        work_next  = 64'h0;
                    end else begin
                        state_next   = DIV_ON;
                        cnt_next     = 6'd0;
                        signed_next  = signed_div_i;
                        sign1_next   = opdata1_i[31];
                        sign2_next   = opdata2_i[31];
                        work_next    = {32'h0, neg_if(opdata1_i, signed_div_i & opdata1_i[31])};
                        divisor_next = neg_if(opdata2_i, signed_div_i & opdata2_i[31]);
                    end
                end
            end
            DIV_BYZERO: begin
                state_next = DIV_END;
            end
            DIV_ON: begin
                // A flush or a withdrawn request abandons the division.
                if (annul_i || start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                    cnt_next   = 6'd0;
                end else if (cnt_reg == 6'd31) begin
                    state_next = DIV_END;
                    cnt_next   = 6'd0;
                    work_next  = {neg_if(final_rem, signed_reg & sign1_reg),
                                  neg_if(final_quot, signed_reg & (sign1_reg ^ sign2_reg))};
                end else begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + 6'd1;
                end
            end
            default: begin
                if (start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end else begin
                    ready_next  = DIV_RESULT_READY;
                    result_next = work_reg;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= 6'd0;
            work_reg    <= 64'h0;
            divisor_reg <= 32'h0;
            signed_reg  <= 1'b0;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            result_reg  <= 64'h0;
            ready_reg   <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            signed_reg  <= signed_next;
            sign1_reg   <= sign1_next;
            sign2_reg   <= sign2_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: latency/arithmetic reference model, per-cycle output
// comparison, directed corner cases and randomized divides with aborts.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'h0;
    logic [31:0] opdata2_i = 32'h0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: 0 idle, 1 dividing, 2 result presented.
    int          m_phase = 0;
    int          m_left = 0;
    bit          m_zero = 1'b0;
    logic [63:0] m_val = 64'h0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start_i && !annul_i) begin
                    m_val   = ref_div(opdata1_i, opdata2_i, signed_div_i);
                    m_zero  = (opdata2_i == 32'h0);
                    m_left  = m_zero ? 2 : 33;
                    m_phase = 1;
                end
                1: begin
                    if (m_left == 1) m_phase = start_i ? 2 : 0;
                    else if (!m_zero && (annul_i || !start_i)) m_phase = 0;
                    else m_left--;
                end
                default: if (!start_i) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        exp_r;
            logic [63:0] exp_d;
            exp_r = (m_phase == 2);
            exp_d = exp_r ? m_val : 64'h0;
            n_checks++;
            if (ready_o !== exp_r || result_o !== exp_d) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t: ready=%b result=%h expected ready=%b result=%h",
                         $time, ready_o, result_o, exp_r, exp_d);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input int hold, output int lat, output logic [63:0] res);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = sg;
        start_i = 1'b1;
        wait_ready(lat);
        res = result_o;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, "_hold"}, {63'h0, ready_o}, 64'h1);
        end
        start_i = 1'b0;
        tick();
        chk({name, "_drop"}, {63'h0, ready_o}, 64'h0);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;

        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_ready", {63'h0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);

        // Pin the reference model against hand-computed values.
        chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("model_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 3, lat, res);
        chk("u100_7_lat", 64'(lat), 64'd33);
        chk("u100_7_res", res, {32'd2, 32'd14});

        run_div("s-7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 0, lat, res);
        chk("s-7_2_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, lat, res);
        chk("s_min_m1_res", res, {32'h0, 32'h8000_0000});

        run_div("u_max_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 0, lat, res);
        chk("u_max_1_res", res, {32'h0, 32'hFFFF_FFFF});

        run_div("div0", 32'h1234_5678, 32'h0, 1'b1, 2, lat, res);
        chk("div0_lat", 64'(lat), 64'd2);
        chk("div0_res", res, 64'h0);

        // Operands wander during ON; the captured values must win.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        signed_div_i = 1'b0;
        start_i = 1'b1;
        repeat (6) tick();
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = 1'b1;
        wait_ready(lat);
        chk("opchg_res", result_o, {32'd1, 32'd111});
        start_i = 1'b0;
        tick();

        // annul_i in FREE blocks the start.
        opdata1_i = 32'd5;
        opdata2_i = 32'd1;
        signed_div_i = 1'b0;
        annul_i = 1'b1;
        start_i = 1'b1;
        repeat (3) tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("annul_free_blocks", {63'h0, ready_o}, 64'h0);

        // Annul sampled at N+10, then an immediate new request must be accepted at N+11.
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        tick();
        repeat (9) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        chk("annul_ready", {63'h0, ready_o}, 64'h0);
        run_div("after_annul", 32'd20, 32'd3, 1'b0, 0, lat, res);
        chk("after_annul_lat", 64'(lat), 64'd33);
        chk("after_annul_res", res, {32'd2, 32'd6});

        // Reset pulse mid-division.
        opdata1_i = 32'd500;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        tick();
        repeat (14) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_mid_result", result_o, 64'h0);
        rst = 1'b0;
        start_i = 1'b0;
        repeat (40) tick();
        run_div("after_rst", 32'd500, 32'd7, 1'b0, 0, lat, res);
        chk("after_rst_res", res, {32'd3, 32'd71});

        // Randomized divides, some withdrawn or flushed part-way.
        for (int t = 0; t < 30; t++) begin
            logic [31:0] a, b;
            logic        sg;
            int          mode;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            sg = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            if (mode < 2) begin
                run_div($sformatf("rnd%0d", t), a, b, sg, $urandom_range(0, 3), lat, res);
                chk($sformatf("rnd%0d_lat", t), 64'(lat), (b == 32'h0) ? 64'd2 : 64'd33);
                chk($sformatf("rnd%0d_res", t), res, ref_div(a, b, sg));
            end else begin
                opdata1_i = a;
                opdata2_i = b;
                signed_div_i = sg;
                start_i = 1'b1;
                tick();
                repeat ($urandom_range(1, 30)) tick();
                if (mode == 2) start_i = 1'b0;
                else annul_i = 1'b1;
                tick();
                annul_i = 1'b0;
                start_i = 1'b0;
                tick();
                chk($sformatf("rnd%0d_abort", t), {63'h0, ready_o}, 64'h0);
            end
        end

        repeat (2) tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
